// File: rtl/gray_monitor_pkg.sv
// Shared definitions for the Gray counter monitor: FSM states and fault codes.
package gray_monitor_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StTrack = 2'b01,
    StFault = 2'b10
  } mon_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_STEP = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

endpackage

// File: rtl/gray_monitor_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_monitor_gray2bin #(
  parameter int unsigned GRAY_W = 3
) (
  input  logic [GRAY_W-1:0] i_gray,
  output logic [GRAY_W-1:0] o_bin
);

  for (genvar i = 0; i < GRAY_W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[GRAY_W-1:i];
  end

endmodule

// File: rtl/gray_monitor.sv
// Checker for a Gray counter stage: tracks position and wraps, flags illegal steps and
// disagreement with the upstream overflow flag, and latches the first fault.
module gray_monitor
  import gray_monitor_pkg::*;
#(
  parameter int unsigned GRAY_W = 3,
  parameter int unsigned WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [GRAY_W-1:0] Gray,
  input  logic              Overflow_in,
  output logic [GRAY_W-1:0] Bin,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Locked,
  output logic              Error,
  output logic [1:0]        ErrCode
);

  localparam logic [GRAY_W-1:0] BinMax  = {GRAY_W{1'b1}};
  localparam logic [WRAP_W-1:0] WrapMax = {WRAP_W{1'b1}};

  mon_state_e        r_state, w_state_d;
  logic [GRAY_W-1:0] r_bin, w_bin_d;
  logic [WRAP_W-1:0] r_wraps, w_wraps_d;
  logic              r_locked, w_locked_d;
  logic [1:0]        r_errcode, w_errcode_d;

  logic [GRAY_W-1:0] w_dec;
  logic [GRAY_W-1:0] w_bin_inc;
  logic [WRAP_W-1:0] w_wraps_nx;
  logic              w_hold, w_inc, w_wrap, w_step_ok, w_ovf_bad;

  gray_monitor_gray2bin #(
    .GRAY_W(GRAY_W)
  ) u_gray2bin (
    .i_gray(Gray),
    .o_bin (w_dec)
  );

  // Step classification and overflow expectation for the sample currently presented.
  always_comb begin
    w_bin_inc  = r_bin + GRAY_W'(1);
    w_hold     = (w_dec == r_bin);
    w_inc      = (w_dec == w_bin_inc);
    w_wrap     = w_inc && (r_bin == BinMax);
    w_wraps_nx = (w_wrap && (r_wraps != WrapMax)) ? r_wraps + WRAP_W'(1) : r_wraps;
    w_step_ok  = w_hold || w_inc;
    // In EMPTY the wrap count is still zero, so this also covers the first-sample check.
    w_ovf_bad  = (Overflow_in != (w_wraps_nx != '0));
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; FAULT only leaves via Reset.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: if (Valid) w_state_d = w_ovf_bad ? StFault : StTrack;
      StTrack: if (Valid && (!w_step_ok || w_ovf_bad)) w_state_d = StFault;
      StFault: w_state_d = StFault;
      default: w_state_d = StEmpty;
    endcase
  end

  // Datapath next values; an illegal step leaves Bin and Wraps at the last good sample.
  always_comb begin
    w_bin_d     = r_bin;
    w_wraps_d   = r_wraps;
    w_locked_d  = r_locked;
    w_errcode_d = r_errcode;
    unique case (r_state)
      StEmpty: begin
        if (Valid) begin
          w_bin_d    = w_dec;
          w_locked_d = 1'b1;
          if (w_ovf_bad) w_errcode_d = ERR_OVF;
        end
      end
      StTrack: begin
        if (Valid) begin
          if (!w_step_ok) begin
            w_errcode_d = ERR_STEP;
          end else begin
            w_bin_d   = w_dec;
            w_wraps_d = w_wraps_nx;
            if (w_ovf_bad) w_errcode_d = ERR_OVF;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bin     <= '0;
      r_wraps   <= '0;
      r_locked  <= 1'b0;
      r_errcode <= ERR_NONE;
    end else begin
      r_bin     <= w_bin_d;
      r_wraps   <= w_wraps_d;
      r_locked  <= w_locked_d;
      r_errcode <= w_errcode_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Bin     = r_bin;
    Wraps   = r_wraps;
    Locked  = r_locked;
    Error   = (r_state == StFault);
    ErrCode = r_errcode;
  end

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor: a vector table for the basic count/wrap path plus
// hand-written sequences for saturation, faults, holds and reset corner cases.
module tb_gray_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] gray = 3'b000;
  logic       ovf = 1'b0;
  logic [2:0] bin;
  logic [3:0] wraps;
  logic       locked;
  logic       error;
  logic [1:0] errcode;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] gray;
    logic       ovf;
    logic [2:0] bin;
    logic [3:0] wraps;
    logic       locked;
    logic       err;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[13];

  gray_monitor #(
    .GRAY_W(3),
    .WRAP_W(4)
  ) dut (
    .Clk        (clk),
    .Reset      (rst),
    .Valid      (valid),
    .Gray       (gray),
    .Overflow_in(ovf),
    .Bin        (bin),
    .Wraps      (wraps),
    .Locked     (locked),
    .Error      (error),
    .ErrCode    (errcode)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] gray_of(input int b);
    logic [2:0] b3;
    b3 = 3'(b);
    return b3 ^ (b3 >> 1);
  endfunction

  // Drive inputs away from the edge, then sample 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [2:0] g, input logic o);
    @(negedge clk);
    rst   = r;
    valid = v;
    gray  = g;
    ovf   = o;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] eb, input logic [3:0] ew,
                       input logic el, input logic ee, input logic [1:0] ec);
    n_checks++;
    if (bin !== eb || wraps !== ew || locked !== el || error !== ee || errcode !== ec) begin
      n_errors++;
      $display("FAIL %s: got Bin=%0d Wraps=%0d Locked=%b Error=%b ErrCode=%b, need Bin=%0d Wraps=%0d Locked=%b Error=%b ErrCode=%b",
               name, bin, wraps, locked, error, errcode, eb, ew, el, ee, ec);
    end
  endtask

  task automatic check_err(input string name, input logic ee, input logic [1:0] ec);
    n_checks++;
    if (error !== ee || errcode !== ec) begin
      n_errors++;
      $display("FAIL %s: got Error=%b ErrCode=%b, need Error=%b ErrCode=%b",
               name, error, errcode, ee, ec);
    end
  endtask

  initial begin
    //          rst   vld   gray    ovf   bin   wraps locked err   code
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[2]  = '{1'b0, 1'b1, 3'b001, 1'b0, 3'd1, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 3'b011, 1'b0, 3'd2, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 3'b010, 1'b0, 3'd3, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[5]  = '{1'b0, 1'b1, 3'b110, 1'b0, 3'd4, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[6]  = '{1'b0, 1'b1, 3'b111, 1'b0, 3'd5, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[7]  = '{1'b0, 1'b1, 3'b101, 1'b0, 3'd6, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[8]  = '{1'b0, 1'b1, 3'b100, 1'b0, 3'd7, 4'd0, 1'b1, 1'b0, 2'b00};
    tbl[9]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'd0, 4'd1, 1'b1, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 1'b0, 3'b110, 1'b0, 3'd0, 4'd1, 1'b1, 1'b0, 2'b00};
    tbl[11] = '{1'b0, 1'b1, 3'b000, 1'b1, 3'd0, 4'd1, 1'b1, 1'b0, 2'b00};
    tbl[12] = '{1'b0, 1'b1, 3'b001, 1'b1, 3'd1, 4'd1, 1'b1, 1'b0, 2'b00};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].valid, tbl[i].gray, tbl[i].ovf);
      check($sformatf("vec%0d", i), tbl[i].bin, tbl[i].wraps, tbl[i].locked, tbl[i].err,
            tbl[i].code);
    end

    // 16 further full cycles from Bin=1: wrap count climbs to 15 and saturates without error.
    for (int c = 0; c < 16; c++) begin
      for (int k = 2; k < 10; k++) begin
        drive(1'b0, 1'b1, gray_of(k % 8), 1'b1);
        if (k == 8) begin
          check($sformatf("sat_wrap%0d", c), 3'd0, 4'((c + 2 > 15) ? 15 : c + 2), 1'b1, 1'b0,
                2'b00);
        end
      end
    end

    // Illegal step 2 -> 4, then frozen against further samples.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 1'b0);
    drive(1'b0, 1'b1, 3'b011, 1'b0);
    drive(1'b0, 1'b1, 3'b110, 1'b0);
    check("step_err", 3'd2, 4'd0, 1'b1, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 3'b010, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 1'b1);
    check("step_frozen", 3'd2, 4'd0, 1'b1, 1'b1, 2'b01);

    // Holds are legal; 7 -> 0 without overflow is a mismatch.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 3'b011, 1'b0);
    check("hold", 3'd2, 4'd0, 1'b1, 1'b0, 2'b00);
    for (int b = 3; b < 8; b++) drive(1'b0, 1'b1, gray_of(b), 1'b0);
    check("at_max", 3'd7, 4'd0, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 3'b000, 1'b0);
    check_err("ovf_missing", 1'b1, 2'b10);

    // Reset coinciding with Valid wins; first sample afterwards may be any code.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 1'b0);
    drive(1'b1, 1'b1, 3'b011, 1'b0);
    check("rst_valid", 3'd0, 4'd0, 1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 3'b101, 1'b0);
    check("relock", 3'd6, 4'd0, 1'b1, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 3'b100, 1'b0);
    check("relock_inc", 3'd7, 4'd0, 1'b1, 1'b0, 2'b00);

    // Valid low for 10 cycles holds state; then illegal step plus overflow mismatch.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 3'(i), 1'(i));
      check($sformatf("idle%0d", i), 3'd1, 4'd0, 1'b1, 1'b0, 2'b00);
    end
    drive(1'b0, 1'b1, 3'b111, 1'b1);
    check("both_err", 3'd1, 4'd0, 1'b1, 1'b1, 2'b01);

    // Overflow asserted on the very first sample with no wraps seen.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b011, 1'b1);
    check_err("first_ovf", 1'b1, 2'b10);

    // Upstream reset seen as 3 -> 0 is an illegal step.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 1'b0);
    drive(1'b0, 1'b1, 3'b011, 1'b0);
    drive(1'b0, 1'b1, 3'b010, 1'b0);
    drive(1'b0, 1'b1, 3'b000, 1'b0);
    check("upstream_rst", 3'd3, 4'd0, 1'b1, 1'b1, 2'b01);

    // Reset clears a latched fault.
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    check("fault_clear", 3'd0, 4'd0, 1'b0, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
